ntt_iter_core: RTL and testbench
================================

// Module: ntt_iter_core
// PURPOSE
//  Parametrised iterative NTT engine: one radix-2 butterfly per cycle over an in-place
//  N-word register buffer. Adds inverse mode (GS + n_inv scaling) and valid/ready streaming.
//  Sits between the host load/unload path and polynomial-arithmetic blocks; serves as a
//  low-area companion to the 8-PE NTT top level.
// PARAMETERS
//  DW    16  coefficient/modulus width; q < 2^(DW-1)
//  LOGN  8   log2 of polynomial length N = 2^LOGN (LOGN >= 2)
// PORTS
//  clk        in   1       rising-edge clock; single clock domain
//  reset      in   1       asynchronous, active-low reset
//  load_w     in   1       command (IDLE only): load 2N+2 words: tw_fwd[0..N-1], tw_inv[0..N-1], q, n_inv
//  load_data  in   1       command (IDLE only): load N coefficients, natural order
//  start      in   1       command (IDLE only): run transform
//  inv        in   1       sampled with start: 0 = forward, 1 = inverse
//  in_valid   in   1       din qualifier
//  in_ready   out  1       high in LOADW/LOADD
//  din        in   DW      load word
//  out_valid  out  1       dout qualifier
//  out_ready  in   1       sink accept
//  dout       out  DW      result coefficient, natural order 0..N-1
//  busy       out  1       state != IDLE
//  done       out  1       1-cycle pulse on acceptance of the last output word
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, out_valid, busy, done = 0; dout=0; q=n_inv=0; counters=0.
//   Twiddle tables and data buffer are not cleared.
//  Commands: priority load_w > load_data > start; all ignored outside IDLE.
//  FSM: IDLE -> LOADW | LOADD | COMP.
//   LOADW -> IDLE after 2N+2 accepted words.
//   LOADD -> IDLE after N accepted words.
//   COMP -> SCALE (inv=1) | OUT (inv=0).
//   SCALE -> OUT.
//   OUT -> IDLE after N accepted words.
//  Load: a word is accepted when in_valid & in_ready; counter advances only on accept.
//   Gaps are allowed.
//  Forward (CT): k=1; for len=N/2 down to 1; for s=0 step 2len: w=tw_fwd[k++];
//   for j=s..s+len-1:
//     v = w*x[j+len] mod q
//     x[j] = x[j]+v mod q
//     x[j+len] = x[j]-v mod q
//  Inverse (GS): k=1; for len=1 up to N/2; for s: w=tw_inv[k++]; per j:
//     u = x[j], t = x[j+len]
//     x[j] = u+t mod q
//     x[j+len] = w*(u-t) mod q
//   then SCALE: x[i] = x[i]*n_inv mod q, i=0..N-1.
//   tw_*[0] unused.
//  Timing: COMP takes exactly LOGN*N/2 cycles (one butterfly/cycle, stage order above).
//   SCALE takes exactly N cycles. OUT entered on the following cycle.
//  Arithmetic:
//   add = (DW+1)-bit sum, minus q if >= q
//   sub = u-t, plus q if negative
//   mult = 2DW-bit product mod q
//   Inputs are < q; all results are in [0,q-1].
//  Output: out_valid high throughout OUT. dout = x[idx]; idx advances only on
//   out_valid & out_ready. dout and out_valid are held stable while out_ready=0.
//   done pulses in the cycle after the N-th accept, coincident with return to IDLE.
//  Buffer holds the result after OUT, so start may be re-issued for chaining
//   (forward then inverse).
//  Reset mid-operation: immediate return to IDLE, outputs at reset values,
//   partial buffer contents undefined.
// TESTING (DW=16, LOGN=3, q=17, 16th root 3: tw_fwd[k]=3^brv4(k),
//  tw_inv[k] = inverse twiddles in GS order, n_inv=15)
//  1. load_w, load_data x=[1,0,0,0,0,0,0,0], start inv=0
//     -> outputs 1,1,1,1,1,1,1,1; done one pulse; COMP = 12 cycles.
//  2. load_data x=[1..8], fwd then start inv=1
//     -> outputs 1..8 exactly; SCALE = 8 cycles.
//  3. x = all 16 (q-1), forward + inverse -> all 16; no value >= 17 ever on dout.
//  4. out_ready toggled 1/0 every cycle, and in_valid gaps of 3 cycles during load
//     -> same data as test 1; dout stable while stalled.
//  5. load_w and start asserted together in IDLE -> LOADW entered, start ignored;
//     start during COMP -> ignored.
//  6. reset low at COMP cycle 5 -> busy=0, out_valid=0 next edge;
//     reload and rerun -> test 1 result.

Source files
------------

// File: rtl/ntt_iter_core.sv
// Iterative radix-2 NTT engine: one butterfly per cycle over an in-place N-word register buffer.
// Latency: LOGN*N/2 cycles of COMP, plus N cycles of SCALE in inverse mode, then N words streamed out.
// Backpressure: in_ready is high only in LOADW/LOADD; output index advances only on out_valid & out_ready.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   load_w/load_data/start/inv   commands, honoured only in IDLE (priority load_w > load_data > start)
//   in_valid/in_ready/din        load stream (twiddles, q, n_inv or coefficients)
//   out_valid/out_ready/dout     result stream, natural order 0..N-1
//   busy, done                   status: busy while not IDLE, done pulses on return from OUT
module ntt_iter_core #(
  parameter int DW   = 16,
  parameter int LOGN = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_w,
  input  logic          load_data,
  input  logic          start,
  input  logic          inv,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          done
);

  localparam int N  = 1 << LOGN;
  localparam int CW = LOGN + 2;              // wide enough for 2N+1
  localparam int SW = $clog2(LOGN) + 1;      // holds stage index and stage+1

  localparam logic [CW-1:0] CNT_N     = CW'(N);
  localparam logic [CW-1:0] CNT_NM1   = CW'(N - 1);
  localparam logic [CW-1:0] CNT_2N    = CW'(2 * N);
  localparam logic [CW-1:0] CNT_2NP1  = CW'(2 * N + 1);
  localparam logic [SW-1:0] LAST_STG  = SW'(LOGN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADW,
    S_LOADD,
    S_COMP,
    S_SCALE,
    S_OUT
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;       // load word / scale index / output index
  logic [LOGN-2:0]     bfly_q, bfly_d;     // butterfly index within the current stage
  logic [SW-1:0]       stage_q, stage_d;
  logic [LOGN-1:0]     k_q, k_d;           // twiddle index, bumped at the end of each group
  logic                inv_q, inv_d;
  logic [DW-1:0]       q_q, q_d;
  logic [DW-1:0]       ninv_q, ninv_d;
  logic                done_q, done_d;

  logic [DW-1:0]       x_q      [N];
  logic [DW-1:0]       tw_fwd_q [N];
  logic [DW-1:0]       tw_inv_q [N];

  logic                in_acc, out_acc;
  logic [LOGN-1:0]     cnt_idx;
  logic [SW-1:0]       sh;
  logic [LOGN-1:0]     b_ext, len_v, j_idx, jl_idx;
  logic                grp_last, stg_last;
  logic [DW-1:0]       w_v, a_v, b_v, diff_v, mul_a, mul_b, mul_res, bf_top, bf_bot;

  // ---------------------------------------------------------------------------
  // Modular arithmetic; operands are assumed already reduced (< q).
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] qv);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, qv}) s = s - {1'b0, qv};
    return s[DW-1:0];
  endfunction

  // q < 2^(DW-1) keeps |a-b| small enough that bit DW is a reliable sign.
  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] qv);
    logic [DW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[DW]) d = d + {1'b0, qv};
    return d[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] mod_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] qv);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    return DW'(p % {{DW{1'b0}}, qv});
  endfunction

  assign in_ready  = (state_q == S_LOADW) || (state_q == S_LOADD);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;
  assign cnt_idx   = cnt_q[LOGN-1:0];
  assign dout      = (state_q == S_OUT) ? x_q[cnt_idx] : '0;

  // ---------------------------------------------------------------------------
  // Butterfly addressing. Forward runs len = N/2 .. 1, inverse runs len = 1 .. N/2.
  // Butterfly b of a stage with len = 2^sh touches j = group*2len + offset and j+len,
  // where group = b >> sh and offset = b & (len-1).
  // ---------------------------------------------------------------------------
  always_comb begin
    sh       = inv_q ? stage_q : (LAST_STG - stage_q);
    b_ext    = {1'b0, bfly_q};
    len_v    = LOGN'(1) << sh;
    j_idx    = ((b_ext >> sh) << (sh + 1'b1)) | (b_ext & (len_v - 1'b1));
    jl_idx   = j_idx | len_v;   // bit sh of j is always clear
    grp_last = ((b_ext & (len_v - 1'b1)) == (len_v - 1'b1));
    stg_last = (bfly_q == '1);
  end

  // One shared multiplier: twiddle product during COMP, n_inv scaling during SCALE.
  always_comb begin
    w_v     = inv_q ? tw_inv_q[k_q] : tw_fwd_q[k_q];
    a_v     = x_q[j_idx];
    b_v     = x_q[jl_idx];
    diff_v  = mod_sub(a_v, b_v, q_q);
    mul_a   = (state_q == S_SCALE) ? ninv_q : w_v;
    mul_b   = (state_q == S_SCALE) ? x_q[cnt_idx] : (inv_q ? diff_v : b_v);
    mul_res = mod_mul(mul_a, mul_b, q_q);
    if (inv_q) begin
      bf_top = mod_add(a_v, b_v, q_q);
      bf_bot = mul_res;
    end else begin
      bf_top = mod_add(a_v, mul_res, q_q);
      bf_bot = mod_sub(a_v, mul_res, q_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bfly_d  = bfly_q;
    stage_d = stage_q;
    k_d     = k_q;
    inv_d   = inv_q;
    q_d     = q_q;
    ninv_d  = ninv_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_w) begin
          state_d = S_LOADW;
          cnt_d   = '0;
        end else if (load_data) begin
          state_d = S_LOADD;
          cnt_d   = '0;
        end else if (start) begin
          state_d = S_COMP;
          inv_d   = inv;
          bfly_d  = '0;
          stage_d = '0;
          k_d     = LOGN'(1);
        end
      end

      S_LOADW: begin
        if (in_acc) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_2N) q_d = din;
          if (cnt_q == CNT_2NP1) begin
            ninv_d  = din;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end

      S_LOADD: begin
        if (in_acc) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_NM1) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end

      S_COMP: begin
        bfly_d = bfly_q + 1'b1;
        if (grp_last) k_d = k_q + 1'b1;
        if (stg_last) begin
          stage_d = stage_q + 1'b1;
          if (stage_q == LAST_STG) begin
            cnt_d   = '0;
            state_d = inv_q ? S_SCALE : S_OUT;
          end
        end
      end

      S_SCALE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_NM1) begin
          cnt_d   = '0;
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (out_acc) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_NM1) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bfly_q  <= '0;
      stage_q <= '0;
      k_q     <= '0;
      inv_q   <= 1'b0;
      q_q     <= '0;
      ninv_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bfly_q  <= bfly_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      inv_q   <= inv_d;
      q_q     <= q_d;
      ninv_q  <= ninv_d;
      done_q  <= done_d;
    end
  end

  // Tables and data buffer are deliberately not reset; the FSM only writes them
  // outside IDLE, so a reset freezes their contents.
  always_ff @(posedge clk) begin
    if (state_q == S_LOADW && in_acc) begin
      if (cnt_q < CNT_N)       tw_fwd_q[cnt_idx] <= din;
      else if (cnt_q < CNT_2N) tw_inv_q[cnt_idx] <= din;
    end
    if (state_q == S_LOADD && in_acc) x_q[cnt_idx] <= din;
    if (state_q == S_COMP) begin
      x_q[j_idx]  <= bf_top;
      x_q[jl_idx] <= bf_bot;
    end
    if (state_q == S_SCALE) x_q[cnt_idx] <= mul_res;
  end

endmodule

// File: tb/tb_ntt_iter_core.sv
module tb_ntt_iter_core;
  localparam int DW = 16;
  localparam int LOGN = 3;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset, load_w, load_data, start, inv, in_valid, in_ready;
  logic [DW-1:0] din, dout;
  logic out_valid, out_ready, busy, done;

  int checks = 0;
  int errors = 0;

  // q=17, tw_fwd[k] = 3^brv4(k); tw_inv holds the matching inverses in GS visit order.
  logic [15:0] twf   [8] = '{0, 16, 13, 4, 9, 8, 15, 2};
  logic [15:0] twi   [8] = '{0, 2, 15, 8, 9, 4, 13, 16};
  logic [15:0] delta [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
  logic [15:0] ones  [8] = '{1, 1, 1, 1, 1, 1, 1, 1};
  logic [15:0] ramp  [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  logic [15:0] framp [8] = '{1, 6, 7, 4, 2, 5, 5, 12};
  logic [15:0] all16 [8] = '{16, 16, 16, 16, 16, 16, 16, 16};
  logic [15:0] res   [8];

  ntt_iter_core #(.DW(DW), .LOGN(LOGN)) dut (
    .clk(clk), .reset(reset), .load_w(load_w), .load_data(load_data), .start(start),
    .inv(inv), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w, input int gap);
    in_valid = 1'b1;
    din      = w;
    tick();
    in_valid = 1'b0;
    din      = 16'hdead;
    repeat (gap) tick();
  endtask

  task automatic load_tables(input int gap, input bit issue_cmd);
    logic [15:0] w;
    if (issue_cmd) begin
      load_w = 1'b1;
      tick();
      load_w = 1'b0;
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL loadw_in_ready got %0b exp 1", in_ready); end
    for (int i = 0; i < 2 * N + 2; i++) begin
      if (i < N)            w = twf[i];
      else if (i < 2 * N)   w = twi[i - N];
      else if (i == 2 * N)  w = 16'd17;
      else                  w = 16'd15;
      push_word(w, gap);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL loadw_end_busy got %0b exp 0", busy); end
  endtask

  task automatic load_vec(input logic [15:0] v [8], input int gap);
    load_data = 1'b1;
    tick();
    load_data = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL loadd_in_ready got %0b exp 1", in_ready); end
    for (int i = 0; i < N; i++) push_word(v[i], gap);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL loadd_end_busy got %0b exp 0", busy); end
  endtask

  // Issue start, count cycles until OUT; optionally poke commands mid-COMP.
  task automatic run(input bit inv_b, input int exp_cyc, input bit poke);
    int cnt;
    start = 1'b1;
    inv   = inv_b;
    tick();
    start = 1'b0;
    inv   = 1'b0;
    cnt   = 0;
    while (!out_valid && cnt < 100) begin
      if (poke && cnt == 3) begin start = 1'b1; inv = 1'b1; load_w = 1'b1; load_data = 1'b1; end
      tick();
      start = 1'b0; inv = 1'b0; load_w = 1'b0; load_data = 1'b0;
      cnt++;
    end
    checks++;
    if (cnt !== exp_cyc) begin
      errors++; $display("FAIL run_latency inv=%0b got %0d exp %0d", inv_b, cnt, exp_cyc);
    end
  endtask

  task automatic read_out(input bit toggle);
    int n, cyc;
    bit stalled, early_done;
    logic [15:0] held;
    n = 0; cyc = 0; stalled = 0; early_done = 0; held = '0;
    while (n < N && cyc < 200) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (done === 1'b1) early_done = 1;
      if (stalled) begin
        checks++;
        if (dout !== held || out_valid !== 1'b1) begin
          errors++; $display("FAIL stall_hold got %0d/%0b exp %0d/1", dout, out_valid, held);
        end
      end
      stalled = 0;
      if (out_valid && out_ready) begin res[n] = dout; n++; end
      else if (out_valid) begin held = dout; stalled = 1; end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (n != N) begin errors++; $display("FAIL read_count got %0d exp %0d", n, N); end
    checks++;
    if (early_done) begin errors++; $display("FAIL done_early got 1 exp 0"); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse got done=%0b busy=%0b exp 1/0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_width got %0b exp 0", done); end
  endtask

  task automatic check_res(input string nm, input logic [15:0] e [8]);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (res[i] !== e[i]) begin
        errors++; $display("FAIL %s[%0d] got %0d exp %0d", nm, i, res[i], e[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 0 || in_ready !== 0 || out_valid !== 0 || done !== 0 || dout !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b in_rdy=%0b ov=%0b done=%0b dout=%0d exp all 0",
               busy, in_ready, out_valid, done, dout);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_impulse();
    load_tables(0, 1);
    load_vec(delta, 0);
    run(1'b0, 12, 1'b0);
    read_out(1'b0);
    check_res("impulse", ones);
  endtask

  task automatic test_roundtrip();
    load_vec(ramp, 0);
    run(1'b0, 12, 1'b0);
    read_out(1'b0);
    check_res("ramp_fwd", framp);
    run(1'b1, 20, 1'b0);
    read_out(1'b0);
    check_res("ramp_inv", ramp);
  endtask

  task automatic test_max_value();
    load_vec(all16, 0);
    run(1'b0, 12, 1'b0);
    read_out(1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (res[i] >= 16'd17) begin errors++; $display("FAIL max_range[%0d] got %0d exp <17", i, res[i]); end
    end
    run(1'b1, 20, 1'b0);
    read_out(1'b0);
    check_res("max_inv", all16);
  endtask

  task automatic test_backpressure();
    load_tables(3, 1);
    load_vec(delta, 3);
    run(1'b0, 12, 1'b0);
    read_out(1'b1);
    check_res("stall", ones);
  endtask

  task automatic test_cmd_priority();
    load_w = 1'b1;
    start  = 1'b1;
    tick();
    load_w = 1'b0;
    start  = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL cmd_priority got in_rdy=%0b busy=%0b exp 1/1", in_ready, busy);
    end
    load_tables(0, 0);
    load_vec(delta, 0);
    run(1'b0, 12, 1'b1);
    read_out(1'b0);
    check_res("cmd_in_comp", ones);
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_async got busy=%0b ov=%0b exp 0/0", busy, out_valid);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_edge got busy=%0b ov=%0b ir=%0b exp 0", busy, out_valid, in_ready);
    end
    reset = 1'b1;
    tick();
    load_tables(0, 1);
    load_vec(delta, 0);
    run(1'b0, 12, 1'b0);
    read_out(1'b0);
    check_res("after_reset", ones);
  endtask

  initial begin
    reset = 1'b0; load_w = 0; load_data = 0; start = 0; inv = 0;
    in_valid = 0; din = '0; out_ready = 0;
    #1;
    test_reset();
    test_impulse();
    test_roundtrip();
    test_max_value();
    test_backpressure();
    test_cmd_priority();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
